// File: rtl/calc_op_sequencer.sv
// Command sequencer for a bank of arithmetic units behind an 8:1 result mux.
// Single-cycle ops finish in EXEC; multi-cycle ops wait for unit_done or time out.
module calc_op_sequencer #(
    parameter int unsigned    WIDTH   = 32,
    parameter logic [7:0]     MC_MASK = 8'b1100_0000,
    parameter int unsigned    TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       selector,
    output logic             unit_start,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] mux_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             res_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, res_data_q;
    logic [2:0]       sel_q, res_op_q;
    logic             res_err_q, start_q;

    logic accept, capture, timeout;

    assign accept  = (state_q == IDLE) && cmd_valid;
    // done wins over a coincident timeout
    assign capture = (state_q == EXEC) || ((state_q == WAIT) && unit_done);
    assign timeout = (state_q == WAIT) && !unit_done && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = MC_MASK[cmd_op] ? WAIT : EXEC;
            EXEC: state_d = DONE;
            WAIT: if (unit_done || timeout) state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: cmd_ready = 1'b1;
            DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 8'd0;
        end else if (state_q == WAIT && !unit_done) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 8'd0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sel_q      <= 3'd0;
            res_op_q   <= 3'd0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= accept;
            if (accept) begin
                op_a_q   <= cmd_a;
                op_b_q   <= cmd_b;
                sel_q    <= cmd_op;
                res_op_q <= cmd_op;
            end
            if (capture) begin
                res_data_q <= mux_data;
                res_err_q  <= 1'b0;
            end else if (timeout) begin
                res_data_q <= '0;
                res_err_q  <= 1'b1;
            end
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign selector   = sel_q;
    assign unit_start = start_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign res_err    = res_err_q;

endmodule

// File: doc/calc_op_sequencer.md
CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: width of operands, unit result and captured result.
REQ-002 Parameter MC_MASK, default 8'b1100_0000: bit n set means opcode n is multi-cycle (waits for unit_done).
REQ-003 Parameter TIMEOUT, default 64, legal range 1..255: maximum WAIT cycles before a multi-cycle op is aborted.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  sequencer can accept a command.
REQ-009 cmd_op  input  3  opcode; also used as the result-mux selector value.
REQ-010 cmd_a, cmd_b  input  WIDTH  operands.
REQ-011 op_a, op_b  output  WIDTH  registered operands driven to the arithmetic units.
REQ-012 selector  output  3  registered opcode driven to the 8:1 result mux.
REQ-013 unit_start  output  1  one-cycle pulse that starts the selected unit.
REQ-014 unit_done  input  1  completion strobe from a multi-cycle unit.
REQ-015 mux_data  input  WIDTH  output of the 8:1 result mux.
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  consumer accepts result.
REQ-018 res_data  output  WIDTH  captured result.
REQ-019 res_op  output  3  opcode of the captured result.
REQ-020 res_err  output  1  result aborted by timeout; valid only while res_valid is high.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, WAIT, DONE; one command in flight at a time, no overlap.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge.
REQ-023 On accept: op_a<=cmd_a, op_b<=cmd_b, selector<=cmd_op, res_op<=cmd_op; next state WAIT if MC_MASK[cmd_op] else EXEC.
REQ-024 op_a, op_b, selector SHALL hold their values from acceptance until the next accept.
REQ-025 unit_start SHALL be 1 for exactly the first cycle after acceptance (first cycle of EXEC or WAIT), 0 otherwise.
REQ-026 EXEC (1 cycle): res_data<=mux_data, res_err<=0, next DONE; res_valid rises 2 cycles after the accept edge.
REQ-027 WAIT: 8-bit counter cleared on entry, increments each WAIT cycle without unit_done.
REQ-028 WAIT with unit_done=1: res_data<=mux_data, res_err<=0, next DONE; unit_done in the first WAIT cycle (same cycle as unit_start) is honoured.
REQ-029 WAIT with counter==TIMEOUT-1 and unit_done=0: res_data<=0, res_err<=1, next DONE; unit_done and timeout in the same cycle SHALL resolve as done (res_err=0).
REQ-030 unit_done outside WAIT SHALL be ignored.
REQ-031 DONE: res_valid=1; res_data, res_op, res_err held stable until res_ready=1, then next IDLE.
REQ-032 A command offered in the cycle res_ready completes SHALL NOT be accepted until the following cycle (IDLE).
REQ-033 res_valid SHALL be 1 only in DONE.

Reset
REQ-034 reset SHALL force state IDLE, counter 0, cmd_ready=1 in the following cycle, and op_a, op_b, res_data=0, selector, res_op=0, unit_start, res_valid, res_err=0.
REQ-035 reset SHALL take priority over all other inputs in any state, abandoning any in-flight op with no result produced.

Verification
REQ-036 Single-cycle: reset, cmd_op=3'b001, a=5, b=7, mux_data=12 -> unit_start 1 cycle after accept, res_valid 2 cycles after accept, res_data=12, res_op=1, res_err=0.
REQ-037 Multi-cycle: cmd_op=3'b111, unit_done asserted 10 cycles after unit_start with mux_data=32'hDEAD_BEEF -> res_data=32'hDEAD_BEEF, res_err=0, cmd_ready low throughout.
REQ-038 Timeout: cmd_op=3'b110, TIMEOUT=64, unit_done never -> res_valid after 64 WAIT cycles, res_data=0, res_err=1; then unit_done pulse in IDLE has no effect.
REQ-039 Backpressure: res_ready held 0 for 20 cycles in DONE while cmd_valid=1 and mux_data changes -> res_data stable, cmd_ready=0; res_ready=1 -> IDLE next cycle, new command accepted the cycle after.
REQ-040 Boundary: unit_done coincident with the timeout cycle -> res_err=0 with the mux_data value; unit_done in the same cycle as unit_start -> DONE next cycle.
REQ-041 Reset mid-op: reset asserted in WAIT -> next cycle state IDLE, res_valid=0, unit_start=0, cmd_ready=1; a subsequent unit_done is ignored.
